gray_to_bin: RTL and testbench

// - Converts a WIDTH-bit reflected-binary Gray code word into its plain binary value.
// - The conversion is combinational; the result is registered, so latency is exactly one clock.
// - Sits at clock-domain or encoder boundaries, e.g. FIFO pointer decode and rotary/position sensors.
// - Carries a valid qualifier so that downstream logic knows which outputs are meaningful.
//

---
 rtl/gray_to_bin_comb.sv | 16 +
 rtl/gray_to_bin.sv | 37 +++
 tb/tb_gray_to_bin.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/gray_to_bin_comb.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all
// Gray bits at or above its position. Reusable by other gray-pointer logic.
module gray_to_bin_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each bit is computed as an independent reduction of the upper slice, so
  // there is no bit-to-bit feedback on the bin vector itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_to_bin.sv
// Registered Gray-to-binary converter with a valid qualifier.
// One cycle of latency and full throughput, with no backpressure.
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray,
  input  logic             gray_valid,
  output logic [WIDTH-1:0] bin,
  output logic             bin_valid
);

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] r_bin;
  logic             r_bin_valid;

  gray_to_bin_comb #(.WIDTH(WIDTH)) u_comb (
    .gray (gray),
    .bin  (w_bin)
  );

  // Reset wins over an input in the same cycle; with no valid input, the data register holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin       <= '0;
      r_bin_valid <= 1'b0;
    end else begin
      r_bin_valid <= gray_valid;
      if (gray_valid) r_bin <= w_bin;
    end
  end

  assign bin       = r_bin;
  assign bin_valid = r_bin_valid;

endmodule

// File: tb/tb_gray_to_bin.sv
// Self-checking bench for gray_to_bin at WIDTH=4 and WIDTH=8: directed table,
// exhaustive sweep and randomized traffic against a search-based reference.
module tb_gray_to_bin;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, gv;
  logic [3:0] g, b;
  logic       bv;
  logic       rst8, gv8;
  logic [7:0] g8, b8;
  logic       bv8;

  int checks = 0;
  int errors = 0;

  gray_to_bin #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .gray(g), .gray_valid(gv), .bin(b), .bin_valid(bv)
  );

  gray_to_bin #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .gray(g8), .gray_valid(gv8), .bin(b8), .bin_valid(bv8)
  );

  // Reference: the binary value is the unique n whose Gray encoding n^(n>>1) equals g.
  function automatic int ref_bin(input int gval, input int w);
    for (int n = 0; n < (1 << w); n++)
      if (((n ^ (n >> 1)) & ((1 << w) - 1)) == gval) return n;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       gv;
    logic [3:0] gray;
    logic [3:0] exp_bin;
    logic       exp_vld;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [3:0] m_bin;
    logic       m_vld;
    int         run;

    rst = 1'b1; gv = 1'b0; g = '0;
    rst8 = 1'b1; gv8 = 1'b0; g8 = '0;
    #1;

    // reset with valid input present, then release
    tbl.push_back('{1'b1, 1'b1, 4'hF, 4'h0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'hF, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'hF, 4'h0, 1'b0});
    // directed conversions
    tbl.push_back('{1'b0, 1'b1, 4'hC, 4'h8, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 4'h0, 4'h0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 4'hA, 1'b1});
    // hold when gray_valid drops
    tbl.push_back('{1'b0, 1'b1, 4'h6, 4'h4, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 4'h9, 4'h4, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'h9, 4'h4, 1'b0});
    // mid-stream reset drops the in-flight word
    tbl.push_back('{1'b0, 1'b1, 4'h1, 4'h1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 4'h3, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'h2, 4'h3, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 4'h3, 0});

    foreach (tbl[i]) begin
      rst = tbl[i].rst; gv = tbl[i].gv; g = tbl[i].gray;
      tick();
      chk($sformatf("vec%0d bin", i), int'(b), int'(tbl[i].exp_bin));
      chk($sformatf("vec%0d vld", i), int'(bv), int'(tbl[i].exp_vld));
    end

    // exhaustive back-to-back sweep
    run = 0;
    for (int n = 0; n < 16; n++) begin
      rst = 1'b0; gv = 1'b1; g = 4'(n ^ (n >> 1));
      tick();
      chk($sformatf("sweep%0d bin", n), int'(b), n);
      if (bv) run++;
    end
    gv = 1'b0;
    tick();
    chk("sweep run", run, 16);
    chk("sweep end vld", int'(bv), 0);
    chk("sweep hold", int'(b), 15);

    // randomized traffic against the reference model
    m_bin = b; m_vld = 1'b0;
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 19) == 0);
      gv  = $urandom_range(0, 1);
      g   = 4'($urandom);
      if (rst) begin
        m_bin = '0; m_vld = 1'b0;
      end else begin
        m_vld = gv;
        if (gv) m_bin = 4'(ref_bin(int'(g), 4));
      end
      tick();
      chk("rand bin", int'(b), int'(m_bin));
      chk("rand vld", int'(bv), int'(m_vld));
    end

    // WIDTH=8 boundaries and a few random words
    rst8 = 1'b0; gv8 = 1'b1; g8 = 8'h80;
    tick();
    chk("w8 80", int'(b8), 'hFF);
    chk("w8 vld", int'(bv8), 1);
    g8 = 8'hC0;
    tick();
    chk("w8 C0", int'(b8), 'h80);
    g8 = 8'h00;
    tick();
    chk("w8 00", int'(b8), 0);
    for (int k = 0; k < 20; k++) begin
      g8 = 8'($urandom);
      tick();
      chk("w8 rand", int'(b8), ref_bin(int'(g8), 8));
    end
    gv8 = 1'b0;
    tick();
    chk("w8 vld low", int'(bv8), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
